// File: rtl/fnd_scan_ctrl.sv
// 4-digit FND controller: serial double-dabble binary->BCD conversion behind a valid/ready
// handshake, plus a free-running digit scan. in_ready is low for the whole conversion.
module fnd_scan_ctrl #(
  parameter int TICK_DIV = 100_000,
  parameter int BIN_W    = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [BIN_W-1:0] in_data,
  output logic             in_ready,
  input  logic             blank_en,
  output logic             busy,
  output logic             ovf,
  output logic [3:0]       fndCom,
  output logic [7:0]       fndFont
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int IT_W  = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(9999);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [IT_W-1:0]    iter_q, iter_d;
  logic               pend_ovf_q, pend_ovf_d;
  logic [15:0]        disp_q, disp_d;
  logic               ovf_q, ovf_d;
  logic               blank_q, blank_d;
  logic               tick;
  logic [15:0]        bcd_adj;
  logic [3:0]         lz;
  logic [3:0]         cur_digit;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hBF;
    endcase
  endfunction

  // Scan prescaler and digit index run regardless of the conversion FSM.
  always_comb begin
    tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = tick ? idx_q + 2'd1 : idx_q;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    pend_ovf_d = pend_ovf_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    blank_d    = blank_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          bcd_d  = '0;
          iter_d = '0;
          if (in_data > MAX_VAL) begin
            pend_ovf_d = 1'b1;
            state_d    = S_LOAD;
          end else begin
            pend_ovf_d = 1'b0;
            bin_d      = in_data;
            state_d    = S_CONV;
          end
        end
      end
      S_CONV: begin
        bcd_d  = {bcd_adj[14:0], bin_q[BIN_W-1]};
        bin_d  = {bin_q[BIN_W-2:0], 1'b0};
        iter_d = iter_q + 1'b1;
        if (iter_q == IT_W'(BIN_W - 1)) state_d = S_LOAD;
      end
      S_LOAD: begin
        // blank_en is sampled here so the pins only change on a display update.
        disp_d  = bcd_q;
        ovf_d   = pend_ovf_q;
        blank_d = blank_en;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      pend_ovf_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      blank_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      pend_ovf_q <= pend_ovf_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      blank_q    <= blank_d;
    end
  end

  // A digit is a leading zero when it and every higher digit are zero; digit 0 never is.
  always_comb begin
    lz[3]     = (disp_q[15:12] == 4'd0);
    lz[2]     = lz[3] && (disp_q[11:8] == 4'd0);
    lz[1]     = lz[2] && (disp_q[7:4] == 4'd0);
    lz[0]     = 1'b0;
    cur_digit = disp_q[4*idx_q +: 4];
    if (ovf_q)                  fndFont = 8'hBF;
    else if (blank_q && lz[idx_q]) fndFont = 8'hFF;
    else                        fndFont = seg_code(cur_digit);
  end

  assign fndCom   = ~(4'b0001 << idx_q);
  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: stimulus pushes expected display contents,
// a monitor pops on each completed conversion (busy falling) and checks them.
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [13:0] in_data = '0;
  logic        in_ready;
  logic        blank_en = 1'b0;
  logic        busy;
  logic        ovf;
  logic [3:0]  fndCom;
  logic [7:0]  fndFont;

  fnd_scan_ctrl #(.TICK_DIV(4), .BIN_W(14)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .blank_en(blank_en), .busy(busy), .ovf(ovf),
    .fndCom(fndCom), .fndFont(fndFont)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            ovf;
    logic [3:0][7:0] f;   // f[i] = font expected on digit i
    int              lat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Watch one full scan round (4 digits x 4 clk) and record the font per digit.
  task automatic capture(output logic [3:0][7:0] f, output logic ok);
    f  = {4{8'hXX}};
    ok = 1'b1;
    repeat (16) begin
      @(negedge clk);
      case (fndCom)
        4'b1110: f[0] = fndFont;
        4'b1101: f[1] = fndFont;
        4'b1011: f[2] = fndFont;
        4'b0111: f[3] = fndFont;
        default: ok = 1'b0;
      endcase
    end
  endtask

  // Monitor: a conversion completes when busy falls with reset inactive.
  initial begin
    logic            prev_busy;
    int              bcnt;
    logic [3:0][7:0] f;
    logic            ok;
    exp_t            e;
    prev_busy = 1'b0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_busy = 1'b0;
        bcnt = 0;
      end else if (busy) begin
        bcnt++;
        prev_busy = 1'b1;
      end else if (prev_busy) begin
        if (q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("busy_cycles", bcnt, e.lat);
          chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
          capture(f, ok);
          chk("fndCom_onehot", {31'd0, ok}, 32'd1);
          for (int i = 0; i < 4; i++) chk($sformatf("font_d%0d", i), {24'd0, f[i]}, {24'd0, e.f[i]});
        end
        done_cnt++;
        bcnt = 0;
        prev_busy = 1'b0;
      end
    end
  end

  // Caller is at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input int v, input logic bl, input logic push, input logic o,
                      input logic [3:0][7:0] f);
    exp_t e;
    int   t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    e.ovf = o;
    e.f   = f;
    e.lat = o ? 1 : 15;
    if (push) q.push_back(e);
    in_data  = 14'(v);
    blank_en = bl;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int t = 0;
    while (done_cnt == start && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", {31'd0, done_cnt != start}, 32'd1);
  endtask

  task automatic xact(input int v, input logic bl, input logic o, input logic [3:0][7:0] f);
    int start = done_cnt;
    send(v, bl, 1'b1, o, f);
    wait_done(start);
  endtask

  initial begin
    int              start;
    logic [3:0][7:0] f;
    logic            ok;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_com", {28'd0, fndCom}, 32'h0000_000E);
    chk("rst_font", {24'd0, fndFont}, 32'h0000_00C0);
    reset = 1'b1;

    // Scan order and rate: one digit step every 4 clocks from reset release.
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      chk("scan_com", {28'd0, fndCom}, {28'd0, ~(4'b0001 << (s % 4))});
      chk("scan_font", {24'd0, fndFont}, 32'h0000_00C0);
      repeat (3) @(negedge clk);
    end

    // {digit3, digit2, digit1, digit0}
    xact(1234, 1'b0, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99});
    xact(9999, 1'b1, 1'b0, {8'h90, 8'h90, 8'h90, 8'h90});
    xact(0,    1'b1, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hC0});
    xact(10000, 1'b0, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'hBF});
    xact(510,  1'b0, 1'b0, {8'hC0, 8'h92, 8'hF9, 8'hC0});
    xact(16383, 1'b1, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'hBF});
    xact(1005, 1'b1, 1'b0, {8'hF9, 8'hC0, 8'hC0, 8'h92});

    // A request while busy is dropped; only 42 completes.
    start = done_cnt;
    send(42, 1'b0, 1'b1, 1'b0, {8'hC0, 8'hC0, 8'h99, 8'hA4});
    repeat (3) @(negedge clk);
    chk("busy_mid_conv", {31'd0, busy}, 32'd1);
    in_data  = 14'd77;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(start);
    repeat (4) @(negedge clk);
    chk("no_queued_req", {31'd0, busy}, 32'd0);
    xact(77, 1'b1, 1'b0, {8'hFF, 8'hFF, 8'hF8, 8'hF8});

    // Reset in the middle of converting 8888 aborts it and clears the display.
    send(8888, 1'b0, 1'b0, 1'b0, {4{8'h00}});
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_com", {28'd0, fndCom}, 32'h0000_000E);
    chk("abort_font", {24'd0, fndFont}, 32'h0000_00C0);
    @(negedge clk);
    #2 reset = 1'b1;
    capture(f, ok);
    chk("abort_ready_rel", {31'd0, in_ready}, 32'd1);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("abort_font_d%0d", i), {24'd0, f[i]}, 32'h0000_00C0);

    repeat (40) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
